// File: rtl/sr_pkg.sv
// Shared types and constants for the SR command conditioning path.
package sr_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SET_PULSE,
        RESET_PULSE,
        GAP
    } sr_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser, stability debouncer and rising-edge detector for one
// raw button level; emits a single-cycle request per accepted press.
module sync_debounce
    import sr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic req
);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronised level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= din;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign req = deb_q & ~deb_dly_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns debounced set/reset presses into fixed-width, mutually exclusive
// s/r pulses for the SR stage; colliding requests are dropped and flagged.
module sr_cmd_conditioner
    import sr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    logic             set_req;
    logic             reset_req;
    logic             eff_set;
    logic             eff_reset;

    sr_state_e        state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             set_pend_q, set_pend_d;
    logic             reset_pend_q, reset_pend_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             conflict_q, conflict_d;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (set_btn),
        .req  (set_req)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (reset_btn),
        .req  (reset_req)
    );

    assign eff_set   = set_req | set_pend_q;
    assign eff_reset = reset_req | reset_pend_q;

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        set_pend_d   = set_pend_q;
        reset_pend_d = reset_pend_q;
        conflict_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Everything visible in IDLE is consumed here, served or rejected.
                set_pend_d   = 1'b0;
                reset_pend_d = 1'b0;
                pcnt_d       = '0;
                if (eff_set && eff_reset) begin
                    conflict_d = 1'b1;
                end else if (eff_set) begin
                    state_d = SET_PULSE;
                end else if (eff_reset) begin
                    state_d = RESET_PULSE;
                end
            end
            SET_PULSE, RESET_PULSE: begin
                if (pcnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_d = GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            if (set_req)   set_pend_d   = 1'b1;
            if (reset_req) reset_pend_d = 1'b1;
        end

        s_d    = (state_d == SET_PULSE);
        r_d    = (state_d == RESET_PULSE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            set_pend_q   <= 1'b0;
            reset_pend_q <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            set_pend_q   <= set_pend_d;
            reset_pend_q <= reset_pend_d;
            s_q          <= s_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
            conflict_q   <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule
